// File: rtl/pipeline_mem_wb_skid.sv
// rtl/pipeline_mem_wb_skid.sv - MEM/WB stage register with 2-entry skid buffer, flush and forwarding tap
module pipeline_mem_wb_skid #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dm,
  input  logic [DATA_W-1:0] alu_ea,
  input  logic [RA_W-1:0]   ra,
  input  logic              wb_wb_sel,
  input  logic              wb_data_sel,
  input  logic              wb_reg_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dm_out,
  output logic [DATA_W-1:0] alu_ea_out,
  output logic [RA_W-1:0]   ra_out,
  output logic              wb_wb_sel_out,
  output logic              wb_data_sel_out,
  output logic              wb_reg_en_out,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_ra,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  localparam int PW = 2 * DATA_W + RA_W + 3;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_main;
  logic [PW-1:0]   r_skid;
  logic            r_in_ready;
  logic [PW-1:0]   w_in;
  logic            w_accept;
  logic            w_xfer;

  assign w_in     = {dm, alu_ea, ra, wb_wb_sel, wb_data_sel, wb_reg_en};
  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = (r_state != S_EMPTY) & out_ready;

  // Vacated entries are zeroed so a bubble always presents an all-zero payload.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= S_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_in;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_accept && w_xfer) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid     <= w_in;
            r_state    <= S_SKID;
            r_in_ready <= 1'b0;
          end else if (w_xfer) begin
            r_main  <= '0;
            r_state <= S_EMPTY;
          end
        end
        S_SKID: begin
          if (w_xfer) begin
            r_main     <= r_skid;
            r_skid     <= '0;
            r_state    <= S_FULL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_main     <= '0;
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = (r_state != S_EMPTY);
  assign occupancy       = r_state;
  assign dm_out          = r_main[PW-1 -: DATA_W];
  assign alu_ea_out      = r_main[PW-DATA_W-1 -: DATA_W];
  assign ra_out          = r_main[3 +: RA_W];
  assign wb_wb_sel_out   = r_main[2];
  assign wb_data_sel_out = r_main[1];
  assign wb_reg_en_out   = r_main[0];

  assign fwd_valid = out_valid & wb_reg_en_out;
  assign fwd_ra    = ra_out;
  assign fwd_data  = wb_data_sel_out ? dm_out : alu_ea_out;

endmodule

// File: tb/tb_pipeline_mem_wb_skid.sv
// tb/tb_pipeline_mem_wb_skid.sv - randomized and directed bench for pipeline_mem_wb_skid against a queue model
module tb_pipeline_mem_wb_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] dm, alu_ea, dm_out, alu_ea_out, fwd_data;
  logic [1:0] ra, ra_out, fwd_ra, occupancy;
  logic       wb_wb_sel, wb_data_sel, wb_reg_en;
  logic       wb_wb_sel_out, wb_data_sel_out, wb_reg_en_out, fwd_valid;

  pipeline_mem_wb_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dm(dm), .alu_ea(alu_ea), .ra(ra),
    .wb_wb_sel(wb_wb_sel), .wb_data_sel(wb_data_sel), .wb_reg_en(wb_reg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .dm_out(dm_out), .alu_ea_out(alu_ea_out), .ra_out(ra_out),
    .wb_wb_sel_out(wb_wb_sel_out), .wb_data_sel_out(wb_data_sel_out),
    .wb_reg_en_out(wb_reg_en_out),
    .fwd_valid(fwd_valid), .fwd_ra(fwd_ra), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  // Wide instance
  logic        rst16, flush16, in_valid16, out_ready16, in_ready16, out_valid16;
  logic [15:0] dm16, alu_ea16, dm_out16, alu_ea_out16, fwd_data16;
  logic [3:0]  ra16, ra_out16, fwd_ra16;
  logic        wsel16, dsel16, ren16, wsel_out16, dsel_out16, ren_out16, fwd_valid16;
  logic [1:0]  occupancy16;

  pipeline_mem_wb_skid #(.DATA_W(16), .RA_W(4)) dut16 (
    .clk(clk), .rst(rst16), .flush(flush16),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .dm(dm16), .alu_ea(alu_ea16), .ra(ra16),
    .wb_wb_sel(wsel16), .wb_data_sel(dsel16), .wb_reg_en(ren16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .dm_out(dm_out16), .alu_ea_out(alu_ea_out16), .ra_out(ra_out16),
    .wb_wb_sel_out(wsel_out16), .wb_data_sel_out(dsel_out16),
    .wb_reg_en_out(ren_out16),
    .fwd_valid(fwd_valid16), .fwd_ra(fwd_ra16), .fwd_data(fwd_data16),
    .occupancy(occupancy16)
  );

  // Beat = {dm, alu_ea, ra, wb_wb_sel, wb_data_sel, wb_reg_en}
  typedef struct packed {
    logic [7:0] dm;
    logic [7:0] alu_ea;
    logic [1:0] ra;
    logic       wsel;
    logic       dsel;
    logic       ren;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t cur_in();
    beat_t b;
    b.dm = dm; b.alu_ea = alu_ea; b.ra = ra;
    b.wsel = wb_wb_sel; b.dsel = wb_data_sel; b.ren = wb_reg_en;
    return b;
  endfunction

  // Stage behaves as a 2-deep FIFO whose head is the output register.
  task automatic model_step();
    bit acc, xfr;
    if (rst || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      xfr = (q.size() > 0) && out_ready;
      if (xfr) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
  endtask

  task automatic check_all();
    beat_t h;
    h = (q.size() > 0) ? q[0] : beat_t'(0);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("dm_out", 32'(dm_out), 32'(h.dm));
    chk("alu_ea_out", 32'(alu_ea_out), 32'(h.alu_ea));
    chk("ra_out", 32'(ra_out), 32'(h.ra));
    chk("wb_wb_sel_out", 32'(wb_wb_sel_out), 32'(h.wsel));
    chk("wb_data_sel_out", 32'(wb_data_sel_out), 32'(h.dsel));
    chk("wb_reg_en_out", 32'(wb_reg_en_out), 32'(h.ren));
    chk("fwd_valid", 32'(fwd_valid), 32'((q.size() > 0) && h.ren));
    chk("fwd_ra", 32'(fwd_ra), 32'(h.ra));
    chk("fwd_data", 32'(fwd_data), 32'(h.dsel ? h.dm : h.alu_ea));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [7:0] a,
                       input logic [1:0] r, input bit ws, input bit ds, input bit re);
    in_valid = v; dm = d; alu_ea = a; ra = r;
    wb_wb_sel = ws; wb_data_sel = ds; wb_reg_en = re;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 8'hA5, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    rst16 = 1'b1; flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    dm16 = '0; alu_ea16 = '0; ra16 = '0; wsel16 = 1'b0; dsel16 = 1'b0; ren16 = 1'b0;

    // Reset held two cycles with a beat presented
    cycle(); cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_dm_out", 32'(dm_out), 32'hA5);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'h00, 8'(i), 2'd1, 1'b0, 1'b0, 1'b1);
      cycle();
      chk("stream_alu_ea", 32'(alu_ea_out), 32'(i));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end

    // Back-pressure: A, B fill the stage, C is held off
    in_valid = 1'b0; cycle();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h0A, 2'd1, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'h22, 8'h0B, 2'd2, 1'b0, 1'b0, 1'b1); cycle();
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h33, 8'h0C, 2'd3, 1'b0, 1'b0, 1'b1); cycle();
    chk("bp_hold_ra", 32'(ra_out), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_B_ra", 32'(ra_out), 32'd2);
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    cycle();

    // Flush from SKID with a beat presented
    out_ready = 1'b0;
    drive(1'b1, 8'h44, 8'h01, 2'd1, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'h55, 8'h02, 2'd2, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'h66, 8'h03, 2'd3, 1'b0, 1'b0, 1'b1);
    flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    cycle();

    // Forwarding selection
    out_ready = 1'b1;
    drive(1'b1, 8'h3C, 8'hF0, 2'd2, 1'b0, 1'b1, 1'b1); cycle();
    chk("fwd_dm", 32'(fwd_data), 32'h3C);
    chk("fwd_valid1", 32'(fwd_valid), 32'd1);
    drive(1'b1, 8'h3C, 8'hF0, 2'd2, 1'b0, 1'b0, 1'b1); cycle();
    chk("fwd_alu", 32'(fwd_data), 32'hF0);
    drive(1'b1, 8'h3C, 8'hF0, 2'd2, 1'b0, 1'b0, 1'b0); cycle();
    chk("fwd_valid0", 32'(fwd_valid), 32'd0);

    // Reset and flush together from FULL
    out_ready = 1'b0; in_valid = 1'b0; cycle();
    chk("full_before_rst", 32'(occupancy), 32'd1);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; cycle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst_flush_valid", 32'(out_valid), 32'd0);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0;

    // Wide parameters pass payload intact
    rst16 = 1'b0;
    in_valid16 = 1'b1; dm16 = 16'hBEEF; alu_ea16 = 16'h1234; ra16 = 4'hA;
    dsel16 = 1'b1; ren16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("w16_dm_out", 32'(dm_out16), 32'hBEEF);
    chk("w16_alu_ea_out", 32'(alu_ea_out16), 32'h1234);
    chk("w16_ra_out", 32'(ra_out16), 32'hA);
    chk("w16_fwd_data", 32'(fwd_data16), 32'hBEEF);
    chk("w16_fwd_valid", 32'(fwd_valid16), 32'd1);
    chk("w16_occ", 32'(occupancy16), 32'd1);
    rst16 = 1'b1; flush16 = 1'b1;
    @(posedge clk); #1;
    chk("w16_rst_dm_out", 32'(dm_out16), 32'h0);
    chk("w16_rst_in_ready", 32'(in_ready16), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
